uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//   UART transmit framer, downstream of the parity generator. Accepts an 8-bit byte, the
//   parity mode and the generator's parity_bit, then serialises one frame: start, 8 data
//   bits LSB-first, optional parity, then stop bit(s). Drives the tx pin of the UART link.
// PARAMETERS
//   CLKS_PER_BIT  10416  clock cycles per bit cell (100 MHz / 9600 baud); legal range >= 2
//   STOP_BITS     1      number of stop bits; legal values are 1 or 2
// PORTS
//   clk          in   1  system clock; all state updates on the rising edge
//   reset        in   1  asynchronous, active-low reset
//   tx_start     in   1  request to send; sampled only in IDLE
//   din          in   8  byte to send; sampled with tx_start
//   parity_type  in   2  01 = odd, 10 = even, 00/11 = no parity bit; sampled with tx_start
//   parity_bit   in   1  from the parity generator for din/parity_type; sampled with tx_start
//   tx           out  1  serial line; idles high; registered
//   tx_busy      out  1  high from frame acceptance until the last stop cell ends
//   tx_done      out  1  one-cycle pulse at frame completion
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0, latches=0.
//     Asserting reset mid-frame abandons the frame immediately; no tx_done pulse.
//   States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//     PARITY is skipped (DATA -> STOP) when latched parity_type is 00 or 11.
//   Accept: on the edge where state=IDLE and tx_start=1, latch din, parity_type and
//     parity_bit; set tx=0, tx_busy=1 and baud_cnt=0; go to START. tx falls 1 cycle after accept.
//   tx_start is ignored whenever state!=IDLE. Input changes after accept have no effect.
//   Bit cells: baud_cnt counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1 the cell ends:
//     baud_cnt wraps to 0 and tx is loaded with the next bit value. Every cell, including
//     each stop bit, is exactly CLKS_PER_BIT cycles wide.
//   DATA: a 3-bit bit_idx runs 0..7. tx = latched din[bit_idx]. Leave DATA after bit_idx=7.
//   PARITY: tx = latched parity_bit, for one cell.
//   STOP: tx=1 for STOP_BITS cells; a stop counter tracks the cells.
//   End of the last stop cell: state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle,
//     tx stays 1.
//   Frame length = (10 + P + STOP_BITS - 1) * CLKS_PER_BIT cycles, where P = 1 with parity
//     and P = 0 without.
//   Back-to-back: tx_start may be high during the tx_done cycle. It is accepted on that
//     edge, which gives a minimum line-idle gap of 1 clock after the stop bit(s).
//   tx_done and tx_busy are never high in the same cycle.
// TESTING
//   Use CLKS_PER_BIT=4 and STOP_BITS=1 unless noted.
//   1. din=8'hA5, parity_type=10, parity_bit=0 -> tx cells 0,1,0,1,0,0,1,0,1,0,1
//      (4 cycles each, 44 total); tx_busy high for 44 cycles; then one tx_done pulse.
//   2. din=8'h07, parity_type=01, parity_bit=0 -> cells 0,1,1,1,0,0,0,0,0,0,1; parity cell=0.
//   3. din=8'h00, parity_type=00 (and again with 11) -> 10 cells (40 cycles), no parity
//      cell; stop cell follows bit 7 directly.
//   4. Pulse tx_start with din=8'hFF at cycle 10 of a frame -> ignored; frame completes
//      unchanged; no second frame.
//   5. Assert reset during DATA bit 3 -> tx=1, tx_busy=0 asynchronously; no tx_done;
//      after release, a new tx_start sends a complete, correct frame.
//   6. STOP_BITS=2, tx_start held high, din=8'h55 with no parity -> stop high for 8 cycles;
//      tx_done; second frame start bit begins 1 clock after stop cells end.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte request and serial-line status between a UART client and the frame serialiser
interface uart_tx_frame_if;
  logic       tx_start;
  logic [7:0] din;
  logic [1:0] parity_type;
  logic       parity_bit;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  modport master (output tx_start, din, parity_type, parity_bit, input tx, tx_busy, tx_done);
  modport slave  (input tx_start, din, parity_type, parity_bit, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one UART frame (start, 8 data LSB-first, optional parity, stop bits)
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            reset,
  uart_tx_frame_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [7:0]    din_q;
  logic [1:0]    ptype_q;
  logic          pbit_q;
  logic          cell_end;
  logic          par_en;
  assign cell_end = baud_cnt == CW'(CLKS_PER_BIT - 1);
  assign par_en   = ^ptype_q;
  // frame sequencer; tx is loaded with the next cell value at each cell boundary so it stays registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
      din_q       <= '0;
      ptype_q     <= '0;
      pbit_q      <= 1'b0;
      bus.tx      <= 1'b1;
      bus.tx_busy <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      baud_cnt    <= (state == IDLE || cell_end) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: if (bus.tx_start) begin
          din_q       <= bus.din;
          ptype_q     <= bus.parity_type;
          pbit_q      <= bus.parity_bit;
          bus.tx      <= 1'b0;
          bus.tx_busy <= 1'b1;
          state       <= START;
        end
        START: if (cell_end) begin
          bit_idx <= '0;
          bus.tx  <= din_q[0];
          state   <= DATA;
        end
        DATA: if (cell_end) begin
          if (bit_idx == 3'd7) begin
            stop_cnt <= 1'b0;
            bus.tx   <= par_en ? pbit_q : 1'b1;
            state    <= par_en ? PARITY : STOP;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            bus.tx  <= din_q[bit_idx + 3'd1];
          end
        end
        PARITY: if (cell_end) begin
          stop_cnt <= 1'b0;
          bus.tx   <= 1'b1;
          state    <= STOP;
        end
        STOP: if (cell_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b1;
            state       <= IDLE;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
